// File: rtl/serial_bus_master_if.sv
// serial_bus_master_if: byte-stream and word-bus signals of the serial bus master
interface serial_bus_master_if;
  logic [7:0] rx_data;
  logic rx_valid;
  logic [7:0] tx_data;
  logic tx_start;
  logic tx_active;
  logic [23:0] addr;
  logic [15:0] data_write;
  logic [15:0] data_read;
  logic uds;
  logic lds;
  logic rw;
  logic ack;
  logic busy;
  modport master (
    input rx_data, rx_valid, tx_active, data_read, ack,
    output tx_data, tx_start, addr, data_write, uds, lds, rw, busy
  );
  modport slave (
    output rx_data, rx_valid, tx_active, data_read, ack,
    input tx_data, tx_start, addr, data_write, uds, lds, rw, busy
  );
endinterface

// File: rtl/serial_bus_master.sv
// serial_bus_master: decodes 'R'/'W' byte frames into one 16-bit bus cycle and replies over the byte link
module serial_bus_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic clk,
  input logic reset,
  serial_bus_master_if.master bus
);
  typedef enum logic [3:0] {IDLE, ADR2, ADR1, ADR0, DATH, DATL, BUS, RSP1, RSP2} state_t;
  localparam logic [7:0] TMO = 8'(TIMEOUT);
  state_t state, state_nx;
  logic is_read, err, tx_start, send, cmd_ok, done;
  logic [7:0] timer, tx_data;
  logic [23:0] addr;
  logic [15:0] data_write, rd_q;
  assign cmd_ok = bus.rx_data == 8'h52 || bus.rx_data == 8'h57;
  assign send = (state == RSP1 || state == RSP2) && !bus.tx_active && !tx_start;
  assign done = bus.ack || timer == TMO;
  // state register; reset abandons any frame, bus cycle or pending response
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  // frame walk, bus-cycle end (ack wins over timeout) and response byte sequencing
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = bus.rx_valid && cmd_ok ? ADR2 : IDLE;
      ADR2: state_nx = bus.rx_valid ? ADR1 : ADR2;
      ADR1: state_nx = bus.rx_valid ? ADR0 : ADR1;
      ADR0: state_nx = bus.rx_valid ? (is_read ? BUS : DATH) : ADR0;
      DATH: state_nx = bus.rx_valid ? DATL : DATH;
      DATL: state_nx = bus.rx_valid ? BUS : DATL;
      BUS:  state_nx = done ? RSP1 : BUS;
      RSP1: state_nx = send ? (err || !is_read ? IDLE : RSP2) : RSP1;
      RSP2: state_nx = send ? IDLE : RSP2;
      default: state_nx = IDLE;
    endcase
  end
  // frame fields, ack wait timer, read-data latch and transmit byte register
  always_ff @(posedge clk) begin
    if (reset) begin
      is_read <= 1'b0;
      err <= 1'b0;
      addr <= '0;
      data_write <= '0;
      timer <= '0;
      rd_q <= '0;
      tx_start <= 1'b0;
      tx_data <= '0;
    end else begin
      if (bus.rx_valid) begin
        if (state == IDLE && cmd_ok) is_read <= bus.rx_data == 8'h52;
        if (state == ADR2) addr[23:16] <= bus.rx_data;
        if (state == ADR1) addr[15:8] <= bus.rx_data;
        if (state == ADR0) addr[7:0] <= {bus.rx_data[7:1], 1'b0};
        if (state == DATH) data_write[15:8] <= bus.rx_data;
        if (state == DATL) data_write[7:0] <= bus.rx_data;
      end
      timer <= state == BUS && !bus.ack ? timer + 8'd1 : 8'd0;
      if (state == BUS) err <= !bus.ack;
      if (state == BUS && bus.ack) rd_q <= bus.data_read;
      tx_start <= send;
      if (send) tx_data <= state == RSP2 ? rd_q[7:0] : err ? 8'h45 : is_read ? rd_q[15:8] : 8'h4B;
    end
  end
  assign bus.addr = addr;
  assign bus.data_write = data_write;
  assign bus.uds = state == BUS;
  assign bus.lds = state == BUS;
  assign bus.rw = state == BUS && is_read;
  assign bus.busy = state != IDLE;
  assign bus.tx_start = tx_start;
  assign bus.tx_data = tx_data;
endmodule

// File: tb/tb_serial_bus_master.sv
// tb_serial_bus_master: randomized frames against a frame-level model of the serial bus master
module tb_serial_bus_master;
  localparam int TIMEOUT = 255;
  logic clk, reset;
  serial_bus_master_if bus();
  serial_bus_master #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .reset(reset), .bus(bus));
  int total, bad, viol, tx_len, tx_cnt;
  logic [7:0] txq[$];
  logic [7:0] last_tx;
  logic p_uds, p_start, p_act, p_rw;
  logic [23:0] p_addr;
  logic [15:0] p_dw;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end
  // transmitter model: busy from the tx_start cycle for tx_len cycles
  initial begin
    bus.tx_active = 0;
    tx_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.tx_start) tx_cnt = tx_len;
      else if (tx_cnt > 0) tx_cnt--;
      bus.tx_active = tx_cnt > 0;
    end
  end
  // protocol monitor: collects transmitted bytes and counts rule violations
  initial begin
    viol = 0;
    last_tx = 0;
    {p_uds, p_start, p_act, p_rw, p_addr, p_dw} = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        last_tx = 0;
        {p_uds, p_start, p_act} = '0;
      end else begin
        if (bus.uds !== bus.lds) viol++;
        if (bus.uds && !bus.busy) viol++;
        if (bus.addr[0] !== 1'b0) viol++;
        if (bus.uds && p_uds && (bus.addr !== p_addr || bus.data_write !== p_dw || bus.rw !== p_rw)) viol++;
        if (bus.tx_start) begin
          if (p_start || p_act) viol++;
          txq.push_back(bus.tx_data);
          last_tx = bus.tx_data;
        end else if (bus.tx_data !== last_tx) viol++;
        p_uds = bus.uds; p_start = bus.tx_start; p_act = bus.tx_active;
        p_addr = bus.addr; p_dw = bus.data_write; p_rw = bus.rw;
      end
    end
  end
  function automatic int exp_len(input int d);
    return d <= TIMEOUT ? d + 1 : TIMEOUT + 1;
  endfunction
  function automatic logic [23:0] exp_tx(input logic rd, input int d, input logic [15:0] rdv);
    if (d > TIMEOUT) return {8'd1, 8'h45, 8'h00};
    return rd ? {8'd2, rdv} : {8'd1, 8'h4B, 8'h00};
  endfunction
  function automatic logic [23:0] obs_tx();
    logic [7:0] b0, b1;
    b0 = txq.size() > 0 ? txq[0] : 8'h00;
    b1 = txq.size() > 1 ? txq[1] : 8'h00;
    return {8'(txq.size()), b0, b1};
  endfunction
  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_valid = 1;
    @(negedge clk);
    bus.rx_valid = 0;
    bus.rx_data = 8'($urandom);
  endtask
  task automatic xact(input logic rd, input logic [23:0] a, input logic [15:0] w, input int d,
                      input logic [15:0] rdv, input logic noise, output logic [23:0] oa,
                      output logic [15:0] ow, output logic orw, output int len);
    int g;
    txq.delete();
    tx_len = $urandom_range(1, 5);
    send_byte(rd ? 8'h52 : 8'h57);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    if (!rd) begin
      send_byte(w[15:8]);
      send_byte(w[7:0]);
    end
    g = 0; len = 0; oa = '0; ow = '0; orw = 0;
    while (!bus.uds && g < 10) begin @(negedge clk); g++; end
    while (bus.uds && len < 400) begin
      len++;
      if (len == 1) begin oa = bus.addr; ow = bus.data_write; orw = bus.rw; end
      bus.ack = len == d + 1;
      bus.data_read = bus.ack ? rdv : 16'($urandom);
      bus.rx_valid = noise && $urandom_range(0, 1) == 1;
      bus.rx_data = $urandom_range(0, 1) == 1 ? 8'h52 : 8'h57;
      @(negedge clk);
    end
    bus.ack = 0;
    g = 0;
    while (bus.busy && g < 100) begin
      bus.rx_valid = noise && $urandom_range(0, 1) == 1;
      bus.rx_data = $urandom_range(0, 1) == 1 ? 8'h52 : 8'h57;
      @(negedge clk);
      g++;
    end
    bus.rx_valid = 0;
    repeat (8) @(negedge clk);
  endtask
  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    total++;
    if ({bus.uds, bus.lds, bus.rw, bus.tx_start, bus.busy} !== 5'b0) begin
      bad++; $display("FAIL reset_ctl: got %b want 00000", {bus.uds, bus.lds, bus.rw, bus.tx_start, bus.busy});
    end
    total++;
    if ({bus.addr, bus.data_write, bus.tx_data} !== 48'h0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {bus.addr, bus.data_write, bus.tx_data});
    end
  endtask
  task automatic test_write();
    logic [23:0] oa; logic [15:0] ow; logic orw; int len; int v0;
    v0 = viol;
    xact(0, 24'h001002, 16'hABCD, 3, 16'h0, 0, oa, ow, orw, len);
    total++; if (oa !== 24'h001002) begin bad++; $display("FAIL write_addr: got %h want 001002", oa); end
    total++; if (ow !== 16'hABCD) begin bad++; $display("FAIL write_data: got %h want abcd", ow); end
    total++; if (orw !== 1'b0) begin bad++; $display("FAIL write_rw: got %b want 0", orw); end
    total++; if (len !== 4) begin bad++; $display("FAIL write_len: got %0d want 4", len); end
    total++; if (obs_tx() !== 24'h014B00) begin bad++; $display("FAIL write_tx: got %h want 014b00", obs_tx()); end
    total++; if (viol !== v0) begin bad++; $display("FAIL write_proto: got %0d want %0d", viol, v0); end
  endtask
  task automatic test_read();
    logic [23:0] oa; logic [15:0] ow; logic orw; int len; int v0;
    v0 = viol;
    xact(1, 24'hFF0005, 16'h0, 1, 16'h1234, 0, oa, ow, orw, len);
    total++; if (oa !== 24'hFF0004) begin bad++; $display("FAIL read_addr: got %h want ff0004", oa); end
    total++; if (orw !== 1'b1) begin bad++; $display("FAIL read_rw: got %b want 1", orw); end
    total++; if (len !== 2) begin bad++; $display("FAIL read_len: got %0d want 2", len); end
    total++; if (obs_tx() !== 24'h021234) begin bad++; $display("FAIL read_tx: got %h want 021234", obs_tx()); end
    total++; if (viol !== v0) begin bad++; $display("FAIL read_proto: got %0d want %0d", viol, v0); end
  endtask
  task automatic test_timeout();
    logic [23:0] oa; logic [15:0] ow; logic orw; int len; int v0;
    v0 = viol;
    xact(1, 24'h000000, 16'h0, TIMEOUT + 5, 16'hBEEF, 0, oa, ow, orw, len);
    total++; if (len !== exp_len(TIMEOUT + 5)) begin bad++; $display("FAIL timeout_len: got %0d want %0d", len, exp_len(TIMEOUT + 5)); end
    total++; if (obs_tx() !== 24'h014500) begin bad++; $display("FAIL timeout_tx: got %h want 014500", obs_tx()); end
    xact(1, 24'h00A0B1, 16'h0, TIMEOUT, 16'h5AA5, 0, oa, ow, orw, len);
    total++; if (len !== TIMEOUT + 1) begin bad++; $display("FAIL ack_at_limit_len: got %0d want %0d", len, TIMEOUT + 1); end
    total++; if (obs_tx() !== 24'h025AA5) begin bad++; $display("FAIL ack_at_limit_tx: got %h want 025aa5", obs_tx()); end
    total++; if (viol !== v0) begin bad++; $display("FAIL timeout_proto: got %0d want %0d", viol, v0); end
  endtask
  task automatic test_garbage();
    logic [23:0] oa; logic [15:0] ow; logic orw; int len;
    send_byte(8'h00);
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL garbage_00_busy: got %b want 0", bus.busy); end
    send_byte(8'h41);
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL garbage_41_busy: got %b want 0", bus.busy); end
    xact(0, 24'h123457, 16'h0F0F, 2, 16'h0, 0, oa, ow, orw, len);
    total++; if ({oa, ow} !== {24'h123456, 16'h0F0F}) begin bad++; $display("FAIL garbage_frame: got %h want 1234560f0f", {oa, ow}); end
    total++; if (obs_tx() !== 24'h014B00) begin bad++; $display("FAIL garbage_tx: got %h want 014b00", obs_tx()); end
  endtask
  task automatic test_overrun();
    logic [23:0] oa; logic [15:0] ow; logic orw; int len;
    xact(1, 24'h00C0DE, 16'h0, 4, 16'hCAFE, 1, oa, ow, orw, len);
    total++; if (obs_tx() !== 24'h02CAFE) begin bad++; $display("FAIL overrun_tx: got %h want 02cafe", obs_tx()); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL overrun_busy: got %b want 0", bus.busy); end
    xact(0, 24'h777776, 16'h4242, 0, 16'h0, 0, oa, ow, orw, len);
    total++; if ({oa, ow, orw} !== {24'h777776, 16'h4242, 1'b0}) begin bad++; $display("FAIL overrun_next: got %h want %h", {oa, ow, orw}, {24'h777776, 16'h4242, 1'b0}); end
    total++; if (obs_tx() !== 24'h014B00) begin bad++; $display("FAIL overrun_next_tx: got %h want 014b00", obs_tx()); end
  endtask
  task automatic test_reset_mid_bus();
    logic [23:0] oa; logic [15:0] ow; logic orw; int len; int g;
    txq.delete();
    send_byte(8'h52); send_byte(8'h31); send_byte(8'h32); send_byte(8'h33);
    g = 0;
    while (!bus.uds && g < 10) begin @(negedge clk); g++; end
    repeat (2) @(negedge clk);
    total++; if (bus.uds !== 1'b1) begin bad++; $display("FAIL midbus_strobe: got %b want 1", bus.uds); end
    reset = 1;
    @(negedge clk);
    total++; if ({bus.uds, bus.lds, bus.busy} !== 3'b0) begin bad++; $display("FAIL midbus_abort: got %b want 000", {bus.uds, bus.lds, bus.busy}); end
    total++; if (bus.addr !== 24'h0) begin bad++; $display("FAIL midbus_addr: got %h want 0", bus.addr); end
    reset = 0;
    repeat (10) @(negedge clk);
    total++; if (txq.size() !== 0) begin bad++; $display("FAIL midbus_no_tx: got %0d want 0", txq.size()); end
    xact(0, 24'hABCDEF, 16'h9876, 1, 16'h0, 0, oa, ow, orw, len);
    total++; if ({oa, ow} !== {24'hABCDEE, 16'h9876}) begin bad++; $display("FAIL midbus_next: got %h want abcdee9876", {oa, ow}); end
    total++; if (obs_tx() !== 24'h014B00) begin bad++; $display("FAIL midbus_next_tx: got %h want 014b00", obs_tx()); end
  endtask
  task automatic test_back_to_back();
    logic [23:0] oa, a; logic [15:0] ow, w, rdv; logic orw, rd, noise; int len, d, v0;
    v0 = viol;
    for (int i = 0; i < 30; i++) begin
      rd = 1'($urandom_range(0, 1));
      a = 24'($urandom);
      w = 16'($urandom);
      rdv = 16'($urandom);
      d = i % 10 == 9 ? TIMEOUT + $urandom_range(0, 1) : $urandom_range(0, 8);
      noise = 1'($urandom_range(0, 1));
      xact(rd, a, w, d, rdv, noise, oa, ow, orw, len);
      total++; if (oa !== {a[23:1], 1'b0}) begin bad++; $display("FAIL rand_addr[%0d]: got %h want %h", i, oa, {a[23:1], 1'b0}); end
      total++; if (orw !== rd) begin bad++; $display("FAIL rand_rw[%0d]: got %b want %b", i, orw, rd); end
      if (!rd) begin
        total++; if (ow !== w) begin bad++; $display("FAIL rand_wdata[%0d]: got %h want %h", i, ow, w); end
      end
      total++; if (len !== exp_len(d)) begin bad++; $display("FAIL rand_len[%0d]: got %0d want %0d", i, len, exp_len(d)); end
      total++; if (obs_tx() !== exp_tx(rd, d, rdv)) begin bad++; $display("FAIL rand_tx[%0d]: got %h want %h", i, obs_tx(), exp_tx(rd, d, rdv)); end
    end
    total++; if (viol !== v0) begin bad++; $display("FAIL rand_proto: got %0d want %0d", viol, v0); end
  endtask
  initial begin
    total = 0; bad = 0; tx_len = 1;
    reset = 0;
    bus.rx_data = 0; bus.rx_valid = 0; bus.data_read = 0; bus.ack = 0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_garbage();
    test_overrun();
    test_reset_mid_bus();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
